// File: rtl/inst_dispatch_queue_if.sv
// Decoder-side and dispatch-side signal bundle for inst_dispatch_queue.
// master = decoder/RS/ROB environment, slave = the queue itself.
interface inst_dispatch_queue_if #(
    parameter int IQ_DEPTH = 8,
    parameter int NUM_RS   = 4,
    parameter int PACK_W   = 64,
    parameter int FU_W     = $clog2(NUM_RS)
) ();
    localparam int CNT_W = $clog2(IQ_DEPTH + 1);

    logic              flush;
    logic              in_valid;
    logic [PACK_W-1:0] in_pack;
    logic [FU_W-1:0]   in_fu;
    logic              in_ready;
    logic [NUM_RS-1:0] rs_is_full;
    logic              rob_full;
    logic [NUM_RS-1:0] rs_load;
    logic              rob_alloc;
    logic [PACK_W-1:0] out_pack;
    logic              stall;
    logic              illegal_fu;
    logic [CNT_W-1:0]  count;

    modport master (
        output flush, in_valid, in_pack, in_fu, rs_is_full, rob_full,
        input  in_ready, rs_load, rob_alloc, out_pack, stall, illegal_fu, count
    );

    modport slave (
        input  flush, in_valid, in_pack, in_fu, rs_is_full, rob_full,
        output in_ready, rs_load, rob_alloc, out_pack, stall, illegal_fu, count
    );
endinterface

// File: rtl/inst_dispatch_queue.sv
// In-order instruction dispatch queue feeding NUM_RS reservation stations and the ROB.
// Latency: accept-to-rs_load >= 1 cycle; 0 cycles on an empty queue with DISPATCH_BYPASS_EN.
// Backpressure: in_ready drops only when full or flushing; a blocked head stalls all younger entries.
module inst_dispatch_queue #(
    parameter int IQ_DEPTH = 8,
    parameter int NUM_RS   = 4,
    parameter int PACK_W   = 64,
    parameter int FU_W     = $clog2(NUM_RS)
) (
    input  logic                  clk,
    input  logic                  reset,
    inst_dispatch_queue_if.slave  io
);
    localparam int PTR_W = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
    localparam int CNT_W = $clog2(IQ_DEPTH + 1);

    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PACK_W-1:0] pack_mem_q [IQ_DEPTH];
    logic [FU_W-1:0]   fu_mem_q   [IQ_DEPTH];

    logic [PACK_W-1:0] head_pack;
    logic [FU_W-1:0]   head_fu;
    logic [NUM_RS-1:0] head_sel;
    logic              empty, head_live, head_legal, head_free;
    logic              disp_vld, ill_vld, byp_vld, push_vld, pop_vld, rdy_vld;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(IQ_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        head_pack = pack_mem_q[head_q];
        head_fu   = fu_mem_q[head_q];
        head_sel  = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            head_sel[i] = (head_fu == FU_W'(i));
        end
        // An out-of-range FU index matches no channel, which is what makes it illegal.
        head_legal = |head_sel;
        head_free  = |(head_sel & ~io.rs_is_full);
        empty      = (count_q == '0);
        head_live  = reset & ~empty & ~io.flush;
        disp_vld   = head_live & head_free & ~io.rob_full;
        ill_vld    = head_live & ~head_legal;
        pop_vld    = disp_vld | ill_vld;
        rdy_vld    = reset & (count_q < CNT_W'(IQ_DEPTH)) & ~io.flush;
        push_vld   = io.in_valid & rdy_vld & ~byp_vld;
    end

`ifdef DISPATCH_BYPASS_EN
    logic [NUM_RS-1:0] in_sel;

    always_comb begin
        in_sel = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            in_sel[i] = (io.in_fu == FU_W'(i));
        end
        byp_vld = reset & empty & io.in_valid & ~io.flush & ~io.rob_full
                & (|(in_sel & ~io.rs_is_full));
    end

    always_comb begin
        io.rs_load  = disp_vld ? head_sel : (byp_vld ? in_sel : '0);
        io.out_pack = byp_vld ? io.in_pack : ((reset & ~empty) ? head_pack : '0);
    end
`else
    assign byp_vld = 1'b0;

    always_comb begin
        io.rs_load  = disp_vld ? head_sel : '0;
        io.out_pack = (reset & ~empty) ? head_pack : '0;
    end
`endif

    always_comb begin
        io.in_ready   = rdy_vld;
        io.rob_alloc  = disp_vld | byp_vld;
        io.illegal_fu = ill_vld;
        io.stall      = head_live & ~disp_vld & ~ill_vld;
        io.count      = count_q;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (io.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop_vld)  head_d = ptr_inc(head_q);
            if (push_vld) tail_d = ptr_inc(tail_q);
            case ({push_vld, pop_vld})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset: count_q gates every read.
    always_ff @(posedge clk) begin
        if (push_vld) begin
            pack_mem_q[tail_q] <= io.in_pack;
            fu_mem_q[tail_q]   <= io.in_fu;
        end
    end
endmodule
